// File: rtl/cpu_sequencer.sv
// Fetch/execute phase sequencer for the 8-bit CPU: drives the sm phase bit and the datapath
// clock-enable, stalls execute on IN/OUT handshakes, and handles single-step and HALT parking.
module cpu_sequencer #(
  parameter int CNT_W      = 16,
  parameter int IO_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step_mode,
  input  logic             step,
  input  logic             halt,
  input  logic             in1,
  input  logic             out1,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             sm,
  output logic             ce,
  output logic             in_ack,
  output logic             out_valid,
  output logic             halted,
  output logic             io_err,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_EXEC      = 3'd2,
    S_IO_WAIT   = 3'd3,
    S_STEP_WAIT = 3'd4,
    S_HALT      = 3'd5
  } state_e;

  localparam logic [15:0] TIMEOUT_LAST = 16'(IO_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [15:0]      timer_q, timer_d;

  logic stall;
  logic timeout;
  logic retire;
  logic forced;

  // Handshakes: an input word is consumed on an edge where in1 && in_valid retires (in_ack=1);
  // an output word is taken on an edge where out1 && out_valid && out_ready retires.
  assign stall   = (in1 & ~in_valid) | (out1 & ~out_ready);
  assign timeout = (timer_q == TIMEOUT_LAST);

  always_comb begin
    retire = 1'b0;
    forced = 1'b0;
    case (state_q)
      S_EXEC:    retire = ~stall;
      S_IO_WAIT: begin
        retire = ~stall | timeout;
        forced = stall & timeout;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (run) state_d = S_FETCH;
      S_FETCH: state_d = S_EXEC;
      S_EXEC, S_IO_WAIT: begin
        if (retire) begin
          if (halt)           state_d = S_HALT;
          else if (step_mode) state_d = S_STEP_WAIT;
          else                state_d = S_FETCH;
        end else begin
          state_d = S_IO_WAIT;
        end
      end
      S_STEP_WAIT: if (step || !step_mode) state_d = S_FETCH;
      S_HALT:      if (run) state_d = S_FETCH;
      default:     state_d = S_IDLE;
    endcase
  end

  // Timer only runs while parked in IO_WAIT; entering from EXEC starts it at zero.
  always_comb begin
    timer_d = (state_q == S_IO_WAIT) ? timer_q + 16'd1 : 16'd0;
    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, retire};
    err_d   = err_q;
    if (((state_q == S_IDLE) || (state_q == S_HALT)) && run) err_d = 1'b0;
    else if (forced)                                         err_d = 1'b1;
  end

  always_comb begin
    sm        = 1'b0;
    ce        = 1'b0;
    in_ack    = 1'b0;
    out_valid = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_FETCH: ce = 1'b1;
      S_EXEC, S_IO_WAIT: begin
        sm        = 1'b1;
        ce        = retire;
        in_ack    = in1 & ~stall;
        out_valid = out1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign io_err    = err_q;
  assign instr_cnt = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized bench for cpu_sequencer: an instruction-level model pushes per-cycle expected
// outputs into a queue, and a negedge monitor pops and compares them.
module tb_cpu_sequencer;

  localparam int CW   = 3;
  localparam int IO_T = 5;
  localparam int EW   = 6 + CW;

  logic          clk;
  logic          rst, run, step_mode, step, halt, in1, out1, in_valid, out_ready;
  logic          sm, ce, in_ack, out_valid, halted, io_err;
  logic [CW-1:0] instr_cnt;
  logic [2:0]    dbg_state;

  cpu_sequencer #(.CNT_W(CW), .IO_TIMEOUT(IO_T)) dut (
    .clk(clk), .rst(rst), .run(run), .step_mode(step_mode), .step(step),
    .halt(halt), .in1(in1), .out1(out1), .in_valid(in_valid), .out_ready(out_ready),
    .sm(sm), .ce(ce), .in_ack(in_ack), .out_valid(out_valid), .halted(halted),
    .io_err(io_err), .instr_cnt(instr_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // expected entry: {sm, ce, in_ack, out_valid, halted, io_err, instr_cnt}
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] e;

  // reference model state: what the machine is doing, at instruction level
  logic [CW-1:0] m_cnt;
  logic          m_err;
  logic          m_step;
  int            where;  // 0 idle, 1 running, 2 paused for step, 3 halted

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cmp(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, expv, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp("sm",        CW'(sm),        CW'(e[CW+5]));
      cmp("ce",        CW'(ce),        CW'(e[CW+4]));
      cmp("in_ack",    CW'(in_ack),    CW'(e[CW+3]));
      cmp("out_valid", CW'(out_valid), CW'(e[CW+2]));
      cmp("halted",    CW'(halted),    CW'(e[CW+1]));
      cmp("io_err",    CW'(io_err),    CW'(e[CW]));
      cmp("instr_cnt", instr_cnt,      e[CW-1:0]);
    end
  end

  // driver tasks
  task automatic tick(input logic e_sm, input logic e_ce, input logic e_ack,
                      input logic e_ov, input logic e_hl);
    exp_q.push_back({e_sm, e_ce, e_ack, e_ov, e_hl, m_err, m_cnt});
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_ops();
    halt      = rb();
    in1       = rb();
    out1      = rb();
    in_valid  = rb();
    out_ready = rb();
  endtask

  task automatic park(input int n);
    for (int i = 0; i < n; i++) begin
      rnd_ops();
      if (where == 2) begin
        run       = rb();
        step      = 1'b0;
        step_mode = 1'b1;
      end else begin
        run       = 1'b0;
        step      = rb();
        step_mode = rb();
      end
      tick(1'b0, 1'b0, 1'b0, 1'b0, where == 3);
    end
  endtask

  // how: 0 random, 1 step pulse, 2 leave step mode
  task automatic resume(input int how);
    int h;
    rnd_ops();
    if (where == 2) begin
      h = (how == 0) ? int'($urandom_range(1, 2)) : how;
      run = rb();
      if (h == 1) begin
        step      = 1'b1;
        step_mode = 1'b1;
      end else begin
        step      = 1'b0;
        step_mode = 1'b0;
        m_step    = 1'b0;
      end
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end else begin
      run       = 1'b1;
      step      = rb();
      step_mode = rb();
      tick(1'b0, 1'b0, 1'b0, 1'b0, where == 3);
      m_err = 1'b0;
    end
    where = 1;
    run   = 1'b0;
    step  = 1'b0;
  endtask

  // kind: 0 plain, 1 IN, 2 OUT; d = cycles from first execute cycle until the port is ready
  task automatic do_instr(input int kind, input int d, input logic hlt, input int rst_at);
    int   r;
    logic forced;
    r      = (kind == 0) ? 0 : ((d < IO_T) ? d : IO_T);
    forced = (kind != 0) && (d > IO_T);
    rnd_ops();
    run       = rb();
    step      = rb();
    step_mode = m_step;
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j <= r; j++) begin
      run       = rb();
      step      = rb();
      step_mode = m_step;
      halt      = hlt;
      in1       = (kind == 1);
      out1      = (kind == 2);
      in_valid  = (kind == 1) ? (j >= d) : rb();
      out_ready = (kind == 2) ? (j >= d) : rb();
      if (j < r) begin
        if (j == rst_at) begin
          rst = 1'b1;
          tick(1'b1, 1'b0, 1'b0, kind == 2, 1'b0);
          rst   = 1'b0;
          m_cnt = '0;
          m_err = 1'b0;
          where = 0;
          return;
        end
        tick(1'b1, 1'b0, 1'b0, kind == 2, 1'b0);
      end else begin
        tick(1'b1, 1'b1, (kind == 1) && !forced, kind == 2, 1'b0);
        m_cnt++;
        if (forced) m_err = 1'b1;
        where = hlt ? 3 : (m_step ? 2 : 1);
      end
    end
  endtask

  initial begin
    int kind, d, ra;
    logic hlt;
    rst = 1'b1; run = 1'b0; step_mode = 1'b0; step = 1'b0;
    halt = 1'b0; in1 = 1'b0; out1 = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    m_cnt = '0; m_err = 1'b0; m_step = 1'b0; where = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    park(5);

    // three plain ops then a halt
    resume(0);
    for (int i = 0; i < 3; i++) do_instr(0, 0, 1'b0, -1);
    do_instr(0, 0, 1'b1, -1);
    park(3);

    // IN stalled 4 cycles, OUT timing out, then halt with io_err held
    resume(0);
    do_instr(1, 4, 1'b0, -1);
    do_instr(2, 50, 1'b0, -1);
    do_instr(0, 0, 1'b1, -1);
    park(4);
    resume(0);

    // single-step with pulses spaced apart
    m_step = 1'b1;
    do_instr(0, 0, 1'b0, -1);
    park(5);
    resume(1);
    do_instr(0, 0, 1'b0, -1);
    park(5);
    resume(2);

    // reset while waiting on IN
    do_instr(1, 10, 1'b0, 2);
    park(2);
    resume(0);

    for (int n = 0; n < 250; n++) begin
      if (where != 1) begin
        park($urandom_range(0, 3));
        resume(0);
      end
      if ($urandom_range(0, 5) == 0) m_step = ~m_step;
      kind = $urandom_range(0, 2);
      d    = $urandom_range(0, IO_T + 2);
      hlt  = ($urandom_range(0, 7) == 0);
      ra   = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, IO_T)) : -1;
      do_instr(kind, d, hlt, ra);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Sequences the 8-bit CPU's datapath and control decoder through fetch and execute phases.
- Generates the phase bit `sm` (0 = fetch: IR load, PC increment; 1 = execute) and a datapath clock-enable `ce`.
- Stalls execute for the IN/OUT port handshakes, supports single-step mode, and parks the machine on HALT.
- Sits between the external run/step controls, the instruction decoder (one-hot op lines) and the I/O ports.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- IO_TIMEOUT, 255, number of stalled cycles in IO_WAIT before the I/O instruction is forced to retire (min 1, max 2^16-1).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  start/resume request, sampled every cycle.
- step_mode  input  1  1 = pause after every retired instruction.
- step  input  1  advance one instruction while paused in step mode.
- halt  input  1  decoded HALT op, valid while sm=1.
- in1  input  1  decoded IN op, valid while sm=1.
- out1  input  1  decoded OUT op, valid while sm=1.
- in_valid  input  1  external input data is present.
- out_ready  input  1  external sink can accept output data.
- sm  output  1  phase bit: 0 fetch, 1 execute.
- ce  output  1  datapath register enable (PC, IR, register file, RAM write, flags).
- in_ack  output  1  one-cycle pulse: input data consumed this edge.
- out_valid  output  1  output data valid on the bus this cycle.
- halted  output  1  machine is in HALT.
- io_err  output  1  sticky: an I/O wait timed out.
- instr_cnt  output  CNT_W  retired-instruction count.

Behaviour:
- States: IDLE, FETCH, EXEC, IO_WAIT, STEP_WAIT, HALT.
- Reset (rst=1 at an edge) has absolute priority:
  - state goes to IDLE; instr_cnt=0, io_err=0, wait timer=0.
  - All outputs read 0 in IDLE.
- sm, ce, in_ack, out_valid and halted are decoded from the state and the current inputs. They are not registered.
- IDLE: sm=0, ce=0. run=1 -> FETCH; io_err is cleared on that transition.
- FETCH: sm=0, ce=1; the IR loads and the PC increments at this edge. Always -> EXEC next cycle.
- EXEC: sm=1.
  - Stall condition: (in1 and not in_valid) or (out1 and not out_ready).
    - ce=0, in_ack=0; out_valid=out1.
    - -> IO_WAIT with the wait timer reset to 0.
  - Otherwise the instruction retires this edge:
    - ce=1; instr_cnt increments and wraps modulo 2^CNT_W.
    - in_ack=in1, out_valid=out1.
  - Next state after retiring:
    - halt=1 -> HALT (halt takes priority over step mode);
    - else step_mode=1 -> STEP_WAIT;
    - else -> FETCH.
  - Single-cycle instruction latency: FETCH plus EXEC = 2 cycles when there is no stall.
- IO_WAIT: sm=1; the timer increments each cycle.
  - out_valid=out1 throughout IO_WAIT.
  - Each cycle, the stall condition is re-evaluated on the current inputs.
  - Stall condition clears: retire exactly as in EXEC (ce=1, in_ack pulse for IN, instr_cnt++, same next-state rules).
  - Timer reaches IO_TIMEOUT while still stalled: force retirement.
    - ce=1, in_ack=0; out_valid stays as in IO_WAIT.
    - io_err is set to 1; instr_cnt increments.
    - Same next-state rules as a normal retirement.
  - No transfer is counted on a timeout.
- STEP_WAIT: sm=0, ce=0.
  - step=1 or step_mode=0 -> FETCH.
  - run is ignored in this state.
- HALT: sm=0, ce=0, halted=1.
  - run=1 -> FETCH and io_err is cleared; execution resumes at the current PC.
  - step is ignored in this state.
- run, step and step_mode are ignored in FETCH, EXEC and IO_WAIT.
- The op-line inputs are ignored while sm=0.
- io_err is cleared only by rst or by run out of IDLE/HALT.
- Reset during IO_WAIT abandons the instruction: no ack and no count.

Test Plan:
- rst held for 2 cycles, then released with run=0 for 5 cycles -> sm=0, ce=0, halted=0, instr_cnt=0 throughout.
- run pulse, then 3 plain ops, then halt=1 in the 4th EXEC -> sm toggles 0,1 per cycle; ce=1 every cycle; instr_cnt=4; halted=1 from cycle 9; ce=0 afterwards.
- IN op with in_valid low for 4 cycles, then high -> ce=0 for 4 cycles in sm=1; in_ack pulses once on the 5th execute cycle; instr_cnt increments by 1.
- OUT op with out_ready held 0 and IO_TIMEOUT=3 -> out_valid high for 4 cycles; forced retire on the 4th with ce=1; io_err=1 and stays 1 until a run out of HALT.
- step_mode=1 with 2 step pulses spaced 5 cycles apart -> exactly one FETCH/EXEC pair per pulse; ce=0 between pulses; instr_cnt increments by 2.
- CNT_W=2: retire 5 instructions -> instr_cnt reads 1 (wrap). Separately, assert rst during IO_WAIT -> next cycle shows instr_cnt=0, all outputs 0.
